// File: rtl/double_and_add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : double_and_add_pkg
// Description : Shared encodings for the elliptic-curve double-and-add
//               scalar multiplier: top-level FSM states, the internal
//               arithmetic phase sequence, the point-op selector and the
//               infinity flag.
// Revision    : 1.0 - initial release
// ============================================================================
package double_and_add_pkg;

   localparam int DEFAULT_N = 10;

   // Top-level scalar-multiplication sequence
   typedef enum logic [2:0] {
      ST_LOAD   = 3'd0,
      ST_SCAN   = 3'd1,
      ST_DOUBLE = 3'd2,
      ST_ADD    = 3'd3,
      ST_NEXT   = 3'd4,
      ST_FINISH = 3'd5,
      ST_DONE   = 3'd6
   } state_t;

   // Which lambda numerator/denominator the point-op engine uses
   typedef enum logic {
      OP_DBL = 1'b0,
      OP_ADD = 1'b1
   } op_t;

   // Point-op engine steps: x^2, inverse, lambda, lambda^2, new y
   typedef enum logic [2:0] {
      PH_IDLE = 3'd0,
      PH_SQ   = 3'd1,
      PH_INV  = 3'd2,
      PH_LAM  = 3'd3,
      PH_LSQ  = 3'd4,
      PH_Y    = 3'd5
   } phase_t;

   // Accumulator-at-infinity flag
   localparam logic INF_SET = 1'b1;
   localparam logic INF_CLR = 1'b0;

endpackage
`default_nettype wire

// File: rtl/double_and_add_mod_inverse.sv
`default_nettype none
// ============================================================================
// Module      : double_and_add_mod_inverse
// Description : Modular inverse over an odd prime by binary extended Euclid.
//               One reduction step per clock. start_i loads the operand,
//               done_o pulses for one cycle with inv_o valid.
// Revision    : 1.0 - initial release
// ============================================================================
module double_and_add_mod_inverse #(
   parameter int N = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start_i,
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] p_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [N-1:0] inv_o
);

   logic [N-1:0] u_q, v_q, x1_q, x2_q, inv_q;
   logic         busy_q, done_q;

   // Halve a residue mod p: add p first when odd so the shift is exact
   function automatic logic [N-1:0] f_half(input logic [N-1:0] x, input logic [N-1:0] m);
      logic [N:0] s;
      s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
      return s[N:1];
   endfunction

   // Modular subtraction, adding p back on borrow
   function automatic logic [N-1:0] f_sub(input logic [N-1:0] x, input logic [N-1:0] y,
                                          input logic [N-1:0] m);
      logic [N:0] s;
      if (x >= y) s = {1'b0, x} - {1'b0, y};
      else        s = {1'b0, x} + {1'b0, m} - {1'b0, y};
      return s[N-1:0];
   endfunction

   // Euclid step: invariants u = x1*a and v = x2*a (mod p)
   always_ff @(posedge clk) begin
      if (reset) begin
         u_q    <= '0;
         v_q    <= '0;
         x1_q   <= '0;
         x2_q   <= '0;
         inv_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start_i) begin
            u_q    <= a_i;
            v_q    <= p_i;
            x1_q   <= N'(1);
            x2_q   <= '0;
            busy_q <= 1'b1;
         end else if (busy_q) begin
            if (u_q == N'(1)) begin
               inv_q  <= x1_q;
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end else if (v_q == N'(1)) begin
               inv_q  <= x2_q;
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end else if (u_q == '0) begin
               // zero has no inverse; terminate rather than spin
               inv_q  <= '0;
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end else if (!u_q[0]) begin
               u_q  <= u_q >> 1;
               x1_q <= f_half(x1_q, p_i);
            end else if (!v_q[0]) begin
               v_q  <= v_q >> 1;
               x2_q <= f_half(x2_q, p_i);
            end else if (u_q >= v_q) begin
               u_q  <= u_q - v_q;
               x1_q <= f_sub(x1_q, x2_q, p_i);
            end else begin
               v_q  <= v_q - u_q;
               x2_q <= f_sub(x2_q, x1_q, p_i);
            end
         end
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign inv_o  = inv_q;

endmodule
`default_nettype wire

// File: rtl/double_and_add.sv
`default_nettype none
// ============================================================================
// Module      : double_and_add
// Description : Elliptic-curve scalar multiplier k*P over GF(p), curve
//               y^2 = x^3 + a*x + b, left-to-right binary double-and-add.
//               Self-starting after reset; sticky done with registered
//               result (infinity reported as (0,0)).
// Revision    : 1.0 - initial release
// ============================================================================
module double_and_add
   import double_and_add_pkg::*;
#(
   parameter int N = DEFAULT_N
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] p,
   input  logic [N-1:0] k,
   input  logic [N-1:0] x1,
   input  logic [N-1:0] y1,
   input  logic [N-1:0] a,
   output logic [N-1:0] x3,
   output logic [N-1:0] y3,
   output logic         done
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = $clog2(N + 1);

   state_t         state_q;
   phase_t         ph_q;
   op_t            op_q;
   logic           issued_q;
   logic [IW-1:0]  idx_q;
   logic [N-1:0]   p_q, k_q, xp_q, yp_q, a_q;
   logic [N-1:0]   xq_q, yq_q;
   logic           qinf_q;
   logic [N-1:0]   t_q, inv_val_q, lam_q, xn_q;
   logic [N-1:0]   x3_q, y3_q;
   logic           done_q;

   // multiplier request/response
   logic [N-1:0]   mul_a_q, mul_b_q;
   logic           mul_go_q;
   logic [N-1:0]   ma_q, mb_q, macc_q;
   logic [CW-1:0]  mcnt_q;
   logic           mbusy_q, mul_done_q;
   logic [N:0]     w_md, w_ms;

   // inverter request/response
   logic           inv_go_q;
   logic [N-1:0]   inv_arg_q;
   logic           w_inv_busy, w_inv_done;
   logic [N-1:0]   w_inv_res;

   function automatic logic [N-1:0] f_add(input logic [N-1:0] x, input logic [N-1:0] y,
                                          input logic [N-1:0] m);
      logic [N:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (s >= {1'b0, m}) s = s - {1'b0, m};
      return s[N-1:0];
   endfunction

   function automatic logic [N-1:0] f_sub(input logic [N-1:0] x, input logic [N-1:0] y,
                                          input logic [N-1:0] m);
      logic [N:0] s;
      if (x >= y) s = {1'b0, x} - {1'b0, y};
      else        s = {1'b0, x} + {1'b0, m} - {1'b0, y};
      return s[N-1:0];
   endfunction

   // Lambda operands for both point operations
   logic [N-1:0] w_num_dbl, w_num_add, w_den_dbl, w_den_add, w_xo;
   assign w_num_dbl = f_add(f_add(f_add(t_q, t_q, p_q), t_q, p_q), a_q, p_q);
   assign w_num_add = f_sub(yp_q, yq_q, p_q);
   assign w_den_dbl = f_add(yq_q, yq_q, p_q);
   assign w_den_add = f_sub(xp_q, xq_q, p_q);
   // doubling subtracts xQ twice, addition subtracts xQ and xP
   assign w_xo      = (op_q == OP_DBL) ? xq_q : xp_q;

   // One MSB-first shift-add step: acc = 2*acc + bit*a, each reduced mod p
   always_comb begin
      w_md = {macc_q, 1'b0};
      if (w_md >= {1'b0, p_q}) w_md = w_md - {1'b0, p_q};
      w_ms = w_md + (mb_q[N-1] ? {1'b0, ma_q} : '0);
      if (w_ms >= {1'b0, p_q}) w_ms = w_ms - {1'b0, p_q};
   end

   // Sequential modular multiplier: N steps, done pulses with macc_q final
   always_ff @(posedge clk) begin
      if (reset) begin
         ma_q       <= '0;
         mb_q       <= '0;
         macc_q     <= '0;
         mcnt_q     <= '0;
         mbusy_q    <= 1'b0;
         mul_done_q <= 1'b0;
      end else begin
         mul_done_q <= 1'b0;
         if (mul_go_q) begin
            ma_q    <= mul_a_q;
            mb_q    <= mul_b_q;
            macc_q  <= '0;
            mcnt_q  <= CW'(N);
            mbusy_q <= 1'b1;
         end else if (mbusy_q) begin
            macc_q <= w_ms[N-1:0];
            mb_q   <= mb_q << 1;
            mcnt_q <= mcnt_q - CW'(1);
            if (mcnt_q == CW'(1)) begin
               mbusy_q    <= 1'b0;
               mul_done_q <= 1'b1;
            end
         end
      end
   end

   double_and_add_mod_inverse #(.N(N)) u_inv (
      .clk     (clk),
      .reset   (reset),
      .start_i (inv_go_q),
      .a_i     (inv_arg_q),
      .p_i     (p_q),
      .busy_o  (w_inv_busy),
      .done_o  (w_inv_done),
      .inv_o   (w_inv_res)
   );

   // Main FSM: scan bits, sequence point ops through the arithmetic engine
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_LOAD;
         ph_q      <= PH_IDLE;
         op_q      <= OP_DBL;
         issued_q  <= 1'b0;
         idx_q     <= '0;
         p_q       <= '0;
         k_q       <= '0;
         xp_q      <= '0;
         yp_q      <= '0;
         a_q       <= '0;
         xq_q      <= '0;
         yq_q      <= '0;
         qinf_q    <= INF_SET;
         t_q       <= '0;
         inv_val_q <= '0;
         lam_q     <= '0;
         xn_q      <= '0;
         mul_a_q   <= '0;
         mul_b_q   <= '0;
         mul_go_q  <= 1'b0;
         inv_go_q  <= 1'b0;
         inv_arg_q <= '0;
         x3_q      <= '0;
         y3_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         mul_go_q <= 1'b0;
         inv_go_q <= 1'b0;
         if (ph_q != PH_IDLE) begin
            case (ph_q)
               PH_SQ: begin
                  if (!issued_q) begin
                     mul_a_q  <= xq_q;
                     mul_b_q  <= xq_q;
                     mul_go_q <= 1'b1;
                     issued_q <= 1'b1;
                  end else if (mul_done_q) begin
                     t_q      <= macc_q;
                     issued_q <= 1'b0;
                     ph_q     <= PH_INV;
                  end
               end
               PH_INV: begin
                  if (!issued_q && !w_inv_busy) begin
                     inv_arg_q <= (op_q == OP_DBL) ? w_den_dbl : w_den_add;
                     inv_go_q  <= 1'b1;
                     issued_q  <= 1'b1;
                  end else if (issued_q && w_inv_done) begin
                     inv_val_q <= w_inv_res;
                     issued_q  <= 1'b0;
                     ph_q      <= PH_LAM;
                  end
               end
               PH_LAM: begin
                  if (!issued_q) begin
                     mul_a_q  <= (op_q == OP_DBL) ? w_num_dbl : w_num_add;
                     mul_b_q  <= inv_val_q;
                     mul_go_q <= 1'b1;
                     issued_q <= 1'b1;
                  end else if (mul_done_q) begin
                     lam_q    <= macc_q;
                     issued_q <= 1'b0;
                     ph_q     <= PH_LSQ;
                  end
               end
               PH_LSQ: begin
                  if (!issued_q) begin
                     mul_a_q  <= lam_q;
                     mul_b_q  <= lam_q;
                     mul_go_q <= 1'b1;
                     issued_q <= 1'b1;
                  end else if (mul_done_q) begin
                     xn_q     <= f_sub(f_sub(macc_q, xq_q, p_q), w_xo, p_q);
                     issued_q <= 1'b0;
                     ph_q     <= PH_Y;
                  end
               end
               PH_Y: begin
                  if (!issued_q) begin
                     mul_a_q  <= lam_q;
                     mul_b_q  <= f_sub(xq_q, xn_q, p_q);
                     mul_go_q <= 1'b1;
                     issued_q <= 1'b1;
                  end else if (mul_done_q) begin
                     xq_q     <= xn_q;
                     yq_q     <= f_sub(macc_q, yq_q, p_q);
                     qinf_q   <= INF_CLR;
                     issued_q <= 1'b0;
                     ph_q     <= PH_IDLE;
                     if (state_q == ST_DOUBLE) state_q <= ST_ADD;
                     else                      state_q <= ST_NEXT;
                  end
               end
               default: ph_q <= PH_IDLE;
            endcase
         end else begin
            case (state_q)
               ST_LOAD: begin
                  p_q     <= p;
                  k_q     <= k;
                  xp_q    <= x1;
                  yp_q    <= y1;
                  a_q     <= a;
                  xq_q    <= '0;
                  yq_q    <= '0;
                  qinf_q  <= INF_SET;
                  idx_q   <= IW'(N - 1);
                  state_q <= ST_SCAN;
               end
               ST_SCAN: begin
                  if (k_q == '0)          state_q <= ST_FINISH;
                  else if (k_q[idx_q])    state_q <= ST_DOUBLE;
                  else                    idx_q   <= idx_q - IW'(1);
               end
               ST_DOUBLE: begin
                  if (qinf_q == INF_SET || yq_q == '0) begin
                     qinf_q  <= INF_SET;
                     state_q <= ST_ADD;
                  end else begin
                     op_q <= OP_DBL;
                     ph_q <= PH_SQ;
                  end
               end
               ST_ADD: begin
                  if (!k_q[idx_q]) begin
                     state_q <= ST_NEXT;
                  end else if (qinf_q == INF_SET) begin
                     xq_q    <= xp_q;
                     yq_q    <= yp_q;
                     qinf_q  <= INF_CLR;
                     state_q <= ST_NEXT;
                  end else if (xq_q == xp_q) begin
                     if (yq_q == yp_q && yq_q != '0) begin
                        op_q <= OP_DBL;
                        ph_q <= PH_SQ;
                     end else begin
                        // Q = -P, or doubling a point with y = 0
                        qinf_q  <= INF_SET;
                        state_q <= ST_NEXT;
                     end
                  end else begin
                     op_q <= OP_ADD;
                     ph_q <= PH_INV;
                  end
               end
               ST_NEXT: begin
                  if (idx_q == '0) begin
                     state_q <= ST_FINISH;
                  end else begin
                     idx_q   <= idx_q - IW'(1);
                     state_q <= ST_DOUBLE;
                  end
               end
               ST_FINISH: begin
                  x3_q    <= (qinf_q == INF_SET) ? '0 : xq_q;
                  y3_q    <= (qinf_q == INF_SET) ? '0 : yq_q;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end
               ST_DONE: begin
                  state_q <= ST_DONE;
               end
               default: state_q <= ST_LOAD;
            endcase
         end
      end
   end

   assign x3   = x3_q;
   assign y3   = y3_q;
   assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_double_and_add.sv
`default_nettype none
// ============================================================================
// Module      : tb_double_and_add
// Description : Directed self-checking bench for double_and_add on the
//               curve y^2 = x^3 + 2x + 2 over GF(17), base point (5,1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_double_and_add;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [9:0] p = 10'd17, k = '0, x1 = '0, y1 = '0, a = '0;
   logic [9:0] x3, y3;
   logic       done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   double_and_add #(.N(10)) dut (
      .clk   (clk),
      .reset (reset),
      .p     (p),
      .k     (k),
      .x1    (x1),
      .y1    (y1),
      .a     (a),
      .x3    (x3),
      .y3    (y3),
      .done  (done)
   );

   task automatic start_run(input logic [9:0] tp, input logic [9:0] ta,
                            input logic [9:0] tx, input logic [9:0] ty,
                            input logic [9:0] tk);
      @(negedge clk);
      p = tp; a = ta; x1 = tx; y1 = ty; k = tk;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL reset_done: got %0b want 0", done);
      end
      checks++;
      if (x3 !== 10'd0) begin
         errors++; $display("FAIL reset_x3: got %0d want 0", x3);
      end
      checks++;
      if (y3 !== 10'd0) begin
         errors++; $display("FAIL reset_y3: got %0d want 0", y3);
      end
   endtask

   task automatic test_scalar();
      logic [9:0] kv [6] = '{10'd4, 10'd1, 10'd2, 10'd7, 10'd18, 10'd19};
      logic [9:0] ex [6] = '{10'd3, 10'd5, 10'd6, 10'd0, 10'd5,  10'd0};
      logic [9:0] ey [6] = '{10'd1, 10'd1, 10'd3, 10'd6, 10'd16, 10'd0};
      bit ok;
      for (int i = 0; i < 6; i++) begin
         start_run(10'd17, 10'd2, 10'd5, 10'd1, kv[i]);
         wait_done(20000, ok);
         checks++;
         if (ok !== 1'b1) begin
            errors++; $display("FAIL scalar_timeout k=%0d: done never rose", kv[i]);
         end
         checks++;
         if (x3 !== ex[i]) begin
            errors++; $display("FAIL scalar_x3 k=%0d: got %0d want %0d", kv[i], x3, ex[i]);
         end
         checks++;
         if (y3 !== ey[i]) begin
            errors++; $display("FAIL scalar_y3 k=%0d: got %0d want %0d", kv[i], y3, ey[i]);
         end
      end
   endtask

   task automatic test_zero();
      bit ok;
      start_run(10'd17, 10'd2, 10'd5, 10'd1, 10'd0);
      wait_done(10, ok);
      checks++;
      if (ok !== 1'b1) begin
         errors++; $display("FAIL zero_latency: done not high within 10 cycles");
      end
      checks++;
      if (x3 !== 10'd0 || y3 !== 10'd0) begin
         errors++; $display("FAIL zero_result: got (%0d,%0d) want (0,0)", x3, y3);
      end
   endtask

   task automatic test_abort();
      bit ok;
      start_run(10'd17, 10'd2, 10'd5, 10'd1, 10'd4);
      repeat (50) @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL abort_midrun: done got %0b want 0", done);
      end
      // previous run left done=1 from k=0; reset mid-run must keep it low
      reset = 1'b1;
      k = 10'd2;
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || x3 !== 10'd0 || y3 !== 10'd0) begin
         errors++; $display("FAIL abort_reset: got done=%0b (%0d,%0d) want 0 (0,0)", done, x3, y3);
      end
      reset = 1'b0;
      wait_done(20000, ok);
      checks++;
      if (ok !== 1'b1) begin
         errors++; $display("FAIL abort_timeout: done never rose");
      end
      checks++;
      if (x3 !== 10'd6 || y3 !== 10'd3) begin
         errors++; $display("FAIL abort_result: got (%0d,%0d) want (6,3)", x3, y3);
      end
   endtask

   task automatic test_hold();
      bit ok;
      start_run(10'd17, 10'd2, 10'd5, 10'd1, 10'd7);
      wait_done(20000, ok);
      checks++;
      if (ok !== 1'b1) begin
         errors++; $display("FAIL hold_timeout: done never rose");
      end
      p = 10'd23; k = 10'd3; x1 = 10'd1; y1 = 10'd2; a = 10'd9;
      repeat (40) @(negedge clk);
      checks++;
      if (done !== 1'b1 || x3 !== 10'd0 || y3 !== 10'd6) begin
         errors++; $display("FAIL hold_sticky: got done=%0b (%0d,%0d) want 1 (0,6)", done, x3, y3);
      end
   endtask

   task automatic test_y_zero();
      bit ok;
      start_run(10'd17, 10'd2, 10'd5, 10'd0, 10'd2);
      wait_done(20000, ok);
      checks++;
      if (ok !== 1'b1) begin
         errors++; $display("FAIL yzero_timeout: done never rose");
      end
      checks++;
      if (x3 !== 10'd0 || y3 !== 10'd0) begin
         errors++; $display("FAIL yzero_result: got (%0d,%0d) want (0,0)", x3, y3);
      end
   endtask

   initial begin
      test_reset();
      test_scalar();
      test_zero();
      test_abort();
      test_hold();
      test_y_zero();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
